// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared widths and entry record for the ALU reservation station
package rs_pkg;

  localparam int RS_WIDTH   = 31;
  localparam int RS_ROB     = 2;
  localparam int RS_CTRL    = 3;
  localparam int RS_ENTRIES = 4;

  typedef struct packed {
    logic                busy;
    logic                rdy1;
    logic                rdy2;
    logic [RS_WIDTH:0]   val1;
    logic [RS_WIDTH:0]   val2;
    logic [RS_ROB:0]     tag1;
    logic [RS_ROB:0]     tag2;
    logic [RS_CTRL:0]    ctrl;
    logic [RS_ROB:0]     rob;
  } rs_entry_t;

endpackage

// File: rtl/rs_entry.sv
// rtl/rs_entry.sv - one reservation-station slot: storage, write bypass, CDB wakeup, eligibility
module rs_entry
  import rs_pkg::*;
#(
  parameter int WIDTH   = RS_WIDTH,
  parameter int ROB     = RS_ROB,
  parameter int C_WIDTH = RS_CTRL
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_wr,
  input  logic             i_clr,
  input  logic [C_WIDTH:0] i_ctrl,
  input  logic [ROB:0]     i_rob,
  input  logic             i_ready1,
  input  logic             i_ready2,
  input  logic [WIDTH:0]   i_value1,
  input  logic [WIDTH:0]   i_value2,
  input  logic [ROB:0]     i_rob1,
  input  logic [ROB:0]     i_rob2,
  input  logic             i_cdb_valid,
  input  logic [ROB:0]     i_cdb_tag,
  input  logic [WIDTH:0]   i_cdb_result,
  output logic             o_busy,
  output logic             o_eligible,
  output logic [WIDTH:0]   o_src1,
  output logic [WIDTH:0]   o_src2,
  output logic [C_WIDTH:0] o_ctrl,
  output logic [ROB:0]     o_rob
);

  logic             r_busy, r_rdy1, r_rdy2;
  logic [WIDTH:0]   r_val1, r_val2;
  logic [ROB:0]     r_tag1, r_tag2, r_rob;
  logic [C_WIDTH:0] r_ctrl;

  logic w_hit1, w_hit2, w_byp1, w_byp2;

  // Tags only matter for operands still waiting on a producer.
  assign w_hit1 = i_cdb_valid && !r_rdy1 && (r_tag1 == i_cdb_tag);
  assign w_hit2 = i_cdb_valid && !r_rdy2 && (r_tag2 == i_cdb_tag);
  assign w_byp1 = i_cdb_valid && !i_ready1 && (i_rob1 == i_cdb_tag);
  assign w_byp2 = i_cdb_valid && !i_ready2 && (i_rob2 == i_cdb_tag);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= 1'b0;
      r_rdy1 <= 1'b0;
      r_rdy2 <= 1'b0;
      r_val1 <= '0;
      r_val2 <= '0;
      r_tag1 <= '0;
      r_tag2 <= '0;
      r_rob  <= '0;
      r_ctrl <= '0;
    end else if (i_flush) begin
      r_busy <= 1'b0;
    end else if (i_wr) begin
      r_busy <= 1'b1;
      r_rdy1 <= i_ready1 | w_byp1;
      r_rdy2 <= i_ready2 | w_byp2;
      r_val1 <= w_byp1 ? i_cdb_result : i_value1;
      r_val2 <= w_byp2 ? i_cdb_result : i_value2;
      r_tag1 <= i_rob1;
      r_tag2 <= i_rob2;
      r_rob  <= i_rob;
      r_ctrl <= i_ctrl;
    end else begin
      if (i_clr) r_busy <= 1'b0;
      if (r_busy && w_hit1) begin
        r_rdy1 <= 1'b1;
        r_val1 <= i_cdb_result;
      end
      if (r_busy && w_hit2) begin
        r_rdy2 <= 1'b1;
        r_val2 <= i_cdb_result;
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_eligible = r_busy && (r_rdy1 || w_hit1) && (r_rdy2 || w_hit2);
  assign o_src1     = r_rdy1 ? r_val1 : i_cdb_result;
  assign o_src2     = r_rdy2 ? r_val2 : i_cdb_result;
  assign o_ctrl     = r_ctrl;
  assign o_rob      = r_rob;

endmodule

// File: rtl/alu_reservation_station.sv
// rtl/alu_reservation_station.sv - multi-entry ALU reservation station with issue handshake
// RS_AGE_ORDER_EN selects oldest-first issue via an age matrix; otherwise lowest index wins.
module alu_reservation_station
  import rs_pkg::*;
#(
  parameter int WIDTH   = RS_WIDTH,
  parameter int ROB     = RS_ROB,
  parameter int C_WIDTH = RS_CTRL,
  parameter int ENTRIES = RS_ENTRIES
) (
  input  logic                       clk,
  input  logic                       globalReset,
  input  logic                       flush,
  input  logic                       writeReq,
  input  logic [C_WIDTH:0]           ALUControl,
  input  logic [ROB:0]               robInstr,
  input  logic                       ready1,
  input  logic                       ready2,
  input  logic [WIDTH:0]             value1,
  input  logic [WIDTH:0]             value2,
  input  logic [ROB:0]               rob1,
  input  logic [ROB:0]               rob2,
  input  logic                       cdbValid,
  input  logic [ROB:0]               cdbRobEntry,
  input  logic [WIDTH:0]             cdbResult,
  output logic                       full,
  output logic [$clog2(ENTRIES):0]   freeCount,
  output logic                       issueValid,
  input  logic                       issueReady,
  output logic [WIDTH:0]             src1,
  output logic [WIDTH:0]             src2,
  output logic [C_WIDTH:0]           instrInfo,
  output logic [ROB:0]               instrRob
);

  localparam int CW = $clog2(ENTRIES);

  logic [ENTRIES-1:0] w_busy, w_elig, w_alloc, w_sel, w_clr;
  logic [WIDTH:0]     w_src1 [ENTRIES];
  logic [WIDTH:0]     w_src2 [ENTRIES];
  logic [C_WIDTH:0]   w_ctrl [ENTRIES];
  logic [ROB:0]       w_rob  [ENTRIES];
  logic               w_full;
  logic [CW:0]        w_nbusy;

  assign w_full  = &w_busy;
  assign w_alloc = (writeReq && !w_full) ? (~w_busy & (w_busy + ENTRIES'(1))) : '0;
  assign w_clr   = issueReady ? w_sel : '0;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    rs_entry #(
      .WIDTH(WIDTH), .ROB(ROB), .C_WIDTH(C_WIDTH)
    ) u_entry (
      .i_clk        (clk),
      .i_rst_n      (globalReset),
      .i_flush      (flush),
      .i_wr         (w_alloc[g]),
      .i_clr        (w_clr[g]),
      .i_ctrl       (ALUControl),
      .i_rob        (robInstr),
      .i_ready1     (ready1),
      .i_ready2     (ready2),
      .i_value1     (value1),
      .i_value2     (value2),
      .i_rob1       (rob1),
      .i_rob2       (rob2),
      .i_cdb_valid  (cdbValid),
      .i_cdb_tag    (cdbRobEntry),
      .i_cdb_result (cdbResult),
      .o_busy       (w_busy[g]),
      .o_eligible   (w_elig[g]),
      .o_src1       (w_src1[g]),
      .o_src2       (w_src2[g]),
      .o_ctrl       (w_ctrl[g]),
      .o_rob        (w_rob[g])
    );
  end

`ifdef RS_AGE_ORDER_EN
  // r_age[i][j] set means entry i was allocated before entry j.
  logic [ENTRIES-1:0] r_age [ENTRIES];

  always_ff @(posedge clk or negedge globalReset) begin
    if (!globalReset) begin
      for (int i = 0; i < ENTRIES; i++) r_age[i] <= '0;
    end else if (!flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        for (int j = 0; j < ENTRIES; j++) begin
          if (w_alloc[i]) r_age[i][j] <= 1'b0;
          else if (w_busy[i] && w_alloc[j]) r_age[i][j] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_sel[i] = w_elig[i];
      for (int j = 0; j < ENTRIES; j++) begin
        if (j != i && w_elig[j] && r_age[j][i]) w_sel[i] = 1'b0;
      end
    end
  end
`else
  assign w_sel = w_elig & (~w_elig + ENTRIES'(1));
`endif

  always_comb begin
    issueValid = |w_elig;
    src1       = '0;
    src2       = '0;
    instrInfo  = '0;
    instrRob   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (w_sel[i]) begin
        src1      = src1 | w_src1[i];
        src2      = src2 | w_src2[i];
        instrInfo = instrInfo | w_ctrl[i];
        instrRob  = instrRob | w_rob[i];
      end
    end
  end

  always_comb begin
    w_nbusy = '0;
    for (int i = 0; i < ENTRIES; i++) w_nbusy = w_nbusy + (CW+1)'(w_busy[i]);
  end

  assign full      = w_full;
  assign freeCount = (CW+1)'(ENTRIES) - w_nbusy;

endmodule
